apu_shared_arbiter: RTL and testbench
=====================================

APU_SHARED_ARBITER -- requirements
Module: apu_shared_arbiter

Interface
REQ-001 SHALL have parameter NB_CORES, default 4: number of requesting cores (2..16).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4: depth of the response-routing tag FIFO (power of two, 2..16).
REQ-003 SHALL take NARGS_CPU (3), WOP_CPU, NDSFLAGS_CPU (15), NUSFLAGS_CPU (5) and WAPUTYPE from apu_package; datapath width is 32.
REQ-004 SHALL have port clk_i, in, 1: the single clock; all state is updated on its rising edge.
REQ-005 SHALL have port rst_i, in, 1: reset, synchronous and active-high.
REQ-006 SHALL have port core_req_i, in, [NB_CORES]: per-core APU request.
REQ-007 SHALL have port core_gnt_o, out, [NB_CORES]: per-core grant.
REQ-008 SHALL have ports core_type_i [NB_CORES][WAPUTYPE], core_op_i [NB_CORES][WOP_CPU], core_operands_i [NB_CORES][NARGS_CPU][32] and core_flags_i [NB_CORES][NDSFLAGS_CPU], all in: the request payload.
REQ-009 SHALL have ports core_rvalid_o, out, [NB_CORES]; core_rdata_o, out, 32; core_rflags_o, out, NUSFLAGS_CPU: the response, with data and flags broadcast to all cores.
REQ-010 SHALL have ports unit_req_o, out, 1 and unit_gnt_i, in, 1: the request handshake toward the shared FP unit.
REQ-011 SHALL have ports unit_type_o, unit_op_o, unit_operands_o and unit_flags_o, out: the selected payload, with widths as in REQ-008 minus the core dimension.
REQ-012 SHALL have ports unit_rvalid_i, in, 1; unit_rdata_i, in, 32; unit_rflags_i, in, NUSFLAGS_CPU: the unit response.
REQ-013 SHALL have ports outstanding_o, out, $clog2(MAX_OUTSTANDING)+1: FIFO fill level; spurious_o, out, 1: sticky error.

Function
REQ-014 SHALL implement a two-state FSM:
- ARB: a winner is chosen round-robin among asserted core_req_i, starting at rr_ptr.
- HOLD: the winner is frozen.
REQ-015 SHALL drive unit_req_o = (any core_req_i) AND NOT fifo_full, with the unit payload muxed from the selected core.
REQ-016 SHALL handle a handshake (unit_req_o AND unit_gnt_i) combinationally:
- assert core_gnt_o only for the selected core, in the same cycle;
- push that core's index into the tag FIFO;
- set rr_ptr to (selected+1) mod NB_CORES;
- go to ARB.
REQ-017 SHALL move ARB->HOLD when unit_req_o is high and unit_gnt_i is low; in HOLD, selection and payload stay unchanged until the handshake.
REQ-018 SHALL assume cores hold req and payload stable until granted; the unit returns responses strictly in grant order, at most one per cycle.
REQ-019 SHALL respond one cycle after unit_rvalid_i (FIFO non-empty):
- assert core_rvalid_o[head] for exactly one cycle;
- register core_rdata_o and core_rflags_o from the unit;
- pop the FIFO head.
REQ-020 SHALL drop a unit_rvalid_i that arrives while the FIFO is empty: no core_rvalid_o, and spurious_o is set (cleared only by reset).
REQ-021 SHALL block grants while the FIFO is full, even if a pop occurs in the same cycle; the push is accepted in the next cycle.
REQ-022 SHALL allow a push and a pop in the same cycle when the FIFO is not full, leaving outstanding_o unchanged.
REQ-023 SHALL count outstanding_o 0..MAX_OUTSTANDING; read and write pointers wrap modulo MAX_OUTSTANDING.
REQ-024 SHALL give one request -> grant latency of 0 cycles when the unit grants immediately; response -> core latency is 1 cycle.

Reset
REQ-025 SHALL reset to: FSM=ARB, rr_ptr=0, FIFO empty, outstanding_o=0, core_rvalid_o=0, core_rdata_o=0, core_rflags_o=0, spurious_o=0.
REQ-026 SHALL discard all in-flight tags when reset is asserted mid-operation; unit responses arriving after reset for pre-reset requests are treated per REQ-020.
REQ-027 SHALL hold core_gnt_o=0 and unit_req_o=0 during the reset cycle.

Structure
REQ-028 SHALL source NARGS_CPU, WOP_CPU, NDSFLAGS_CPU, NUSFLAGS_CPU and WAPUTYPE from apu_package; the request-payload struct apu_req_t (type, op, operands, flags) is added to apu_package.
REQ-029 SHALL instantiate the tag FIFO as fifo_v3 (common_cells), FALL_THROUGH=0, DATA_WIDTH=$clog2(NB_CORES), DEPTH=MAX_OUTSTANDING; the arbiter logic is local.

Verification
REQ-030 SHALL cover: all 4 cores request continuously, unit_gnt_i=1, responses 3 cycles later -> grants in order 0,1,2,3,0,...; each core_rvalid_o matches its own grant.
REQ-031 SHALL cover: core 2 requests, unit_gnt_i low for 5 cycles while core 0 also requests -> core 2 stays selected with a stable payload, then is granted; core 0 is granted next.
REQ-032 SHALL cover: 4 grants with no responses -> outstanding_o=4, unit_req_o=0; 1 response -> unit_req_o=1 the next cycle.
REQ-033 SHALL cover: unit_rvalid_i with an empty FIFO -> no core_rvalid_o, spurious_o=1 until rst_i.
REQ-034 SHALL cover: a push and a pop in the same cycle at outstanding_o=2 -> outstanding_o stays 2, and the correct core gets rvalid.
REQ-035 SHALL cover: rst_i asserted with 3 outstanding -> outstanding_o=0 and rr_ptr=0 after one cycle; a later unit response sets spurious_o.

Source files
------------

// File: rtl/apu_package.sv
// apu_package: shared APU constants and the request-payload struct used by
// the core-side arbiter and the shared FP unit.
//   NARGS_CPU     operands per request
//   WOP_CPU       opcode width
//   NDSFLAGS_CPU  downstream (request) flag width
//   NUSFLAGS_CPU  upstream (response) flag width
//   WAPUTYPE      APU type selector width
package apu_package;

  localparam int unsigned NARGS_CPU    = 3;
  localparam int unsigned WOP_CPU      = 6;
  localparam int unsigned NDSFLAGS_CPU = 15;
  localparam int unsigned NUSFLAGS_CPU = 5;
  localparam int unsigned WAPUTYPE     = 3;
  localparam int unsigned APU_DATA_W   = 32;

  typedef struct packed {
    logic [WAPUTYPE-1:0]                     apu_type;
    logic [WOP_CPU-1:0]                      op;
    logic [NARGS_CPU-1:0][APU_DATA_W-1:0]    operands;
    logic [NDSFLAGS_CPU-1:0]                 flags;
  } apu_req_t;

  typedef enum logic {
    ARB_ST  = 1'b0,
    HOLD_ST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: small synchronous FIFO, common_cells-compatible parameters.
//   clk_i    clock
//   rst_ni   asynchronous active-low reset
//   flush_i  synchronous clear (empties the FIFO)
//   full_o / empty_o / usage_o  status; usage_o wraps to 0 when full
//   data_i / push_i             write side
//   data_o / pop_i              read side (data_o valid while !empty_o)
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [ADDR_DEPTH-1:0] usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [ADDR_DEPTH-1:0] rd_ptr_q, wr_ptr_q;
  logic [ADDR_DEPTH:0]   cnt_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  bypass, do_push, do_pop;

  assign full_o  = (cnt_q == (ADDR_DEPTH+1)'(DEPTH));
  // In fall-through mode an empty FIFO forwards the incoming word directly.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign empty_o = (cnt_q == '0) && !bypass;
  assign usage_o = cnt_q[ADDR_DEPTH-1:0];
  assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o && !(bypass && pop_i);
  assign do_pop  = pop_i && !empty_o && !bypass;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ADDR_DEPTH'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ADDR_DEPTH'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + (ADDR_DEPTH+1)'(1);
        2'b01:   cnt_q <= cnt_q - (ADDR_DEPTH+1)'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/apu_shared_arbiter.sv
// apu_shared_arbiter: round-robin arbiter sharing one FP unit among
// NB_CORES cores, with a tag FIFO routing in-order responses back.
//   clk_i, rst_i                 clock, synchronous active-high reset
//   core_req_i / core_gnt_o      per-core request handshake
//   core_*_i                     per-core request payload
//   core_rvalid_o                per-core response strobe (1 cycle)
//   core_rdata_o / core_rflags_o registered response, broadcast to all cores
//   unit_req_o / unit_gnt_i      handshake toward the shared unit
//   unit_*_o                     payload of the selected core
//   unit_rvalid_i/rdata/rflags   unit response, strictly in grant order
//   outstanding_o                tag FIFO fill level (0..MAX_OUTSTANDING)
//   spurious_o                   sticky: response arrived with no tag
//
// state   | meaning
// ARB     | selection recomputed each cycle, round-robin from rr_ptr
// HOLD    | unit stalled the request; selection frozen until handshake
module apu_shared_arbiter
  import apu_package::*;
#(
  parameter int unsigned NB_CORES        = 4,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [NB_CORES-1:0]            core_req_i,
  output logic [NB_CORES-1:0]            core_gnt_o,
  input  logic [WAPUTYPE-1:0]            core_type_i     [NB_CORES],
  input  logic [WOP_CPU-1:0]             core_op_i       [NB_CORES],
  input  logic [31:0]                    core_operands_i [NB_CORES][NARGS_CPU],
  input  logic [NDSFLAGS_CPU-1:0]        core_flags_i    [NB_CORES],
  output logic [NB_CORES-1:0]            core_rvalid_o,
  output logic [31:0]                    core_rdata_o,
  output logic [NUSFLAGS_CPU-1:0]        core_rflags_o,
  output logic                           unit_req_o,
  input  logic                           unit_gnt_i,
  output logic [WAPUTYPE-1:0]            unit_type_o,
  output logic [WOP_CPU-1:0]             unit_op_o,
  output logic [31:0]                    unit_operands_o [NARGS_CPU],
  output logic [NDSFLAGS_CPU-1:0]        unit_flags_o,
  input  logic                           unit_rvalid_i,
  input  logic [31:0]                    unit_rdata_i,
  input  logic [NUSFLAGS_CPU-1:0]        unit_rflags_i,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_o,
  output logic                           spurious_o
);

  localparam int unsigned IDX_W = $clog2(NB_CORES);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING);

  arb_state_e             state_q;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d, sel_q, sel_arb, sel, scan_idx, head_idx;
  logic                   found, any_req, handshake;
  logic                   fifo_full, fifo_empty, fifo_pop;
  logic [CNT_W-1:0]       fifo_usage;
  apu_req_t               sel_req;
  logic [NB_CORES-1:0]    rvalid_q;
  logic [31:0]            rdata_q;
  logic [NUSFLAGS_CPU-1:0] rflags_q;
  logic                   spurious_q;

  // First asserted request at or after rr_ptr, wrapping at NB_CORES.
  always_comb begin
    sel_arb  = rr_ptr_q;
    found    = 1'b0;
    scan_idx = rr_ptr_q;
    for (int i = 0; i < int'(NB_CORES); i++) begin
      if (!found && core_req_i[scan_idx]) begin
        found   = 1'b1;
        sel_arb = scan_idx;
      end
      scan_idx = (scan_idx == IDX_W'(NB_CORES-1)) ? '0 : scan_idx + IDX_W'(1);
    end
  end

  assign sel      = (state_q == HOLD_ST) ? sel_q : sel_arb;
  assign rr_ptr_d = (sel == IDX_W'(NB_CORES-1)) ? '0 : sel + IDX_W'(1);

  // Full blocks requests even if a pop lands this cycle; the push waits a cycle.
  assign any_req    = |core_req_i;
  assign unit_req_o = any_req && !fifo_full && !rst_i;
  assign handshake  = unit_req_o && unit_gnt_i;
  assign core_gnt_o = handshake ? (NB_CORES'(1) << sel) : '0;

  always_comb begin
    sel_req.apu_type = core_type_i[sel];
    sel_req.op       = core_op_i[sel];
    sel_req.flags    = core_flags_i[sel];
    for (int a = 0; a < int'(NARGS_CPU); a++) begin
      sel_req.operands[a] = core_operands_i[sel][a];
    end
  end

  assign unit_type_o  = sel_req.apu_type;
  assign unit_op_o    = sel_req.op;
  assign unit_flags_o = sel_req.flags;

  always_comb begin
    for (int a = 0; a < int'(NARGS_CPU); a++) begin
      unit_operands_o[a] = sel_req.operands[a];
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ARB_ST;
      rr_ptr_q <= '0;
      sel_q    <= '0;
    end else begin
      case (state_q)
        ARB_ST: begin
          sel_q <= sel_arb;
          if (handshake) begin
            rr_ptr_q <= rr_ptr_d;
          end else if (unit_req_o) begin
            state_q <= HOLD_ST;
          end
        end
        HOLD_ST: begin
          if (handshake) begin
            rr_ptr_q <= rr_ptr_d;
            state_q  <= ARB_ST;
          end
        end
        default: state_q <= ARB_ST;
      endcase
    end
  end

  // The FIFO's own async reset is unused; flush gives it the synchronous reset.
  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IDX_W),
    .DEPTH        (MAX_OUTSTANDING)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rst_ni  (1'b1),
    .flush_i (rst_i),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage),
    .data_i  (sel),
    .push_i  (handshake),
    .data_o  (head_idx),
    .pop_i   (fifo_pop)
  );

  assign fifo_pop      = unit_rvalid_i && !fifo_empty && !rst_i;
  assign outstanding_o = {fifo_full, fifo_usage};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q   <= '0;
      rdata_q    <= '0;
      rflags_q   <= '0;
      spurious_q <= 1'b0;
    end else begin
      rvalid_q <= '0;
      if (fifo_pop) begin
        rvalid_q <= NB_CORES'(1) << head_idx;
        rdata_q  <= unit_rdata_i;
        rflags_q <= unit_rflags_i;
      end
      if (unit_rvalid_i && fifo_empty) spurious_q <= 1'b1;
    end
  end

  assign core_rvalid_o = rvalid_q;
  assign core_rdata_o  = rdata_q;
  assign core_rflags_o = rflags_q;
  assign spurious_o    = spurious_q;

endmodule

// File: tb/tb_apu_shared_arbiter.sv
// tb_apu_shared_arbiter: directed checks of arbitration order, HOLD
// behaviour, full-FIFO blocking, response routing, spurious responses and
// mid-operation reset for a 4-core / 4-deep configuration.
module tb_apu_shared_arbiter;
  import apu_package::*;

  localparam int unsigned NC = 4;
  localparam int unsigned MO = 4;

  logic                     clk_i;
  logic                     rst_i;
  logic [NC-1:0]            core_req_i;
  logic [NC-1:0]            core_gnt_o;
  logic [WAPUTYPE-1:0]      core_type_i     [NC];
  logic [WOP_CPU-1:0]       core_op_i       [NC];
  logic [31:0]              core_operands_i [NC][NARGS_CPU];
  logic [NDSFLAGS_CPU-1:0]  core_flags_i    [NC];
  logic [NC-1:0]            core_rvalid_o;
  logic [31:0]              core_rdata_o;
  logic [NUSFLAGS_CPU-1:0]  core_rflags_o;
  logic                     unit_req_o;
  logic                     unit_gnt_i;
  logic [WAPUTYPE-1:0]      unit_type_o;
  logic [WOP_CPU-1:0]       unit_op_o;
  logic [31:0]              unit_operands_o [NARGS_CPU];
  logic [NDSFLAGS_CPU-1:0]  unit_flags_o;
  logic                     unit_rvalid_i;
  logic [31:0]              unit_rdata_i;
  logic [NUSFLAGS_CPU-1:0]  unit_rflags_i;
  logic [$clog2(MO):0]      outstanding_o;
  logic                     spurious_o;

  int n_checks = 0;
  int n_fails  = 0;

  apu_shared_arbiter #(.NB_CORES(NC), .MAX_OUTSTANDING(MO)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .core_req_i      (core_req_i),
    .core_gnt_o      (core_gnt_o),
    .core_type_i     (core_type_i),
    .core_op_i       (core_op_i),
    .core_operands_i (core_operands_i),
    .core_flags_i    (core_flags_i),
    .core_rvalid_o   (core_rvalid_o),
    .core_rdata_o    (core_rdata_o),
    .core_rflags_o   (core_rflags_o),
    .unit_req_o      (unit_req_o),
    .unit_gnt_i      (unit_gnt_i),
    .unit_type_o     (unit_type_o),
    .unit_op_o       (unit_op_o),
    .unit_operands_o (unit_operands_o),
    .unit_flags_o    (unit_flags_o),
    .unit_rvalid_i   (unit_rvalid_i),
    .unit_rdata_i    (unit_rdata_i),
    .unit_rflags_i   (unit_rflags_i),
    .outstanding_o   (outstanding_o),
    .spurious_o      (spurious_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge, then return at
  // the falling edge so outputs can be sampled.
  task automatic step(input logic [3:0] req, input logic gnt, input logic rv,
                      input logic [31:0] rd);
    @(posedge clk_i); #1;
    core_req_i    = req;
    unit_gnt_i    = gnt;
    unit_rvalid_i = rv;
    unit_rdata_i  = rd;
    unit_rflags_i = rd[4:0];
    @(negedge clk_i);
  endtask

  task automatic apply_reset();
    @(posedge clk_i); #1;
    rst_i         = 1'b1;
    core_req_i    = '1;
    unit_gnt_i    = 1'b1;
    unit_rvalid_i = 1'b0;
    @(negedge clk_i);
    check_eq("rst_unit_req", 32'(unit_req_o), 32'h0);
    check_eq("rst_core_gnt", 32'(core_gnt_o), 32'h0);
    @(posedge clk_i); #1;
    check_eq("rst_outstanding", 32'(outstanding_o), 32'h0);
    check_eq("rst_rvalid",      32'(core_rvalid_o), 32'h0);
    check_eq("rst_rdata",       core_rdata_o,       32'h0);
    check_eq("rst_rflags",      32'(core_rflags_o), 32'h0);
    check_eq("rst_spurious",    32'(spurious_o),    32'h0);
    rst_i      = 1'b0;
    core_req_i = '0;
    unit_gnt_i = 1'b0;
  endtask

  initial begin
    rst_i         = 1'b1;
    core_req_i    = '0;
    unit_gnt_i    = 1'b0;
    unit_rvalid_i = 1'b0;
    unit_rdata_i  = '0;
    unit_rflags_i = '0;
    for (int c = 0; c < int'(NC); c++) begin
      core_type_i[c]  = WAPUTYPE'(c + 1);
      core_op_i[c]    = WOP_CPU'(10 + c);
      core_flags_i[c] = NDSFLAGS_CPU'(100 + c);
      for (int a = 0; a < int'(NARGS_CPU); a++) begin
        core_operands_i[c][a] = 32'(32'h1000 * c + a);
      end
    end

    apply_reset();

    // All cores request, unit grants every cycle, responds 3 cycles later.
    for (int t = 0; t < 13; t++) begin
      step((t < 8) ? 4'hF : 4'h0, 1'b1, (t >= 3 && t < 11), 32'(32'hA000 + t - 3));
      if (t < 8) begin
        check_eq("rr_gnt", 32'(core_gnt_o), 32'(1) << (t % 4));
        check_eq("rr_op",  32'(unit_op_o),  32'(10 + t % 4));
      end
      if (t >= 4 && t <= 11) begin
        check_eq("rr_rvalid", 32'(core_rvalid_o), 32'(1) << ((t - 4) % 4));
        check_eq("rr_rdata",  core_rdata_o,       32'(32'hA000 + t - 4));
        check_eq("rr_rflags", 32'(core_rflags_o), 32'((32'hA000 + t - 4) & 32'h1F));
      end else begin
        check_eq("rr_rvalid_idle", 32'(core_rvalid_o), 32'h0);
      end
      if (t == 5)  check_eq("rr_outstanding", 32'(outstanding_o), 32'd3);
      if (t == 12) check_eq("rr_drained",     32'(outstanding_o), 32'd0);
    end

    // Core 2 stalled by the unit for 5 cycles while core 0 joins.
    step(4'b0100, 1'b0, 1'b0, 32'h0);
    check_eq("hold_unit_req", 32'(unit_req_o), 32'h1);
    check_eq("hold_gnt0",     32'(core_gnt_o), 32'h0);
    check_eq("hold_op0",      32'(unit_op_o),  32'd12);
    for (int i = 1; i < 5; i++) begin
      step(4'b0101, 1'b0, 1'b0, 32'h0);
      check_eq("hold_op",     32'(unit_op_o),         32'd12);
      check_eq("hold_type",   32'(unit_type_o),       32'd3);
      check_eq("hold_opnd1",  unit_operands_o[1],     32'h0000_2001);
      check_eq("hold_flags",  32'(unit_flags_o),      32'd102);
      check_eq("hold_gnt",    32'(core_gnt_o),        32'h0);
    end
    step(4'b0101, 1'b1, 1'b0, 32'h0);
    check_eq("hold_release_gnt", 32'(core_gnt_o), 32'b0100);
    step(4'b0001, 1'b1, 1'b0, 32'h0);
    check_eq("hold_next_gnt", 32'(core_gnt_o), 32'b0001);
    check_eq("hold_next_op",  32'(unit_op_o),  32'd10);
    step(4'b0000, 1'b0, 1'b1, 32'h0000_00B1);
    check_eq("hold_outstanding", 32'(outstanding_o), 32'd2);
    step(4'b0000, 1'b0, 1'b1, 32'h0000_00B2);
    check_eq("hold_rvalid2", 32'(core_rvalid_o), 32'b0100);
    check_eq("hold_rdata2",  core_rdata_o,       32'h0000_00B1);
    step(4'b0000, 1'b0, 1'b0, 32'h0);
    check_eq("hold_rvalid0", 32'(core_rvalid_o), 32'b0001);
    check_eq("hold_rdata0",  core_rdata_o,       32'h0000_00B2);
    check_eq("hold_drained", 32'(outstanding_o), 32'd0);

    // Fill the FIFO; grants stay blocked until the cycle after a pop.
    for (int i = 0; i < 4; i++) begin
      step(4'hF, 1'b1, 1'b0, 32'h0);
      check_eq("full_fill_gnt", 32'(core_gnt_o), 32'(1) << ((i + 1) % 4));
    end
    step(4'hF, 1'b1, 1'b0, 32'h0);
    check_eq("full_outstanding", 32'(outstanding_o), 32'd4);
    check_eq("full_unit_req",    32'(unit_req_o),    32'h0);
    check_eq("full_gnt",         32'(core_gnt_o),    32'h0);
    step(4'hF, 1'b1, 1'b1, 32'h0000_00C0);
    check_eq("full_pop_unit_req", 32'(unit_req_o), 32'h0);
    check_eq("full_pop_gnt",      32'(core_gnt_o), 32'h0);
    step(4'hF, 1'b1, 1'b0, 32'h0);
    check_eq("after_pop_unit_req",    32'(unit_req_o),    32'h1);
    check_eq("after_pop_gnt",         32'(core_gnt_o),    32'b0010);
    check_eq("after_pop_outstanding", 32'(outstanding_o), 32'd3);
    check_eq("after_pop_rvalid",      32'(core_rvalid_o), 32'b0010);
    check_eq("after_pop_rdata",       core_rdata_o,       32'h0000_00C0);
    step(4'h0, 1'b0, 1'b1, 32'h0000_00C1);
    check_eq("refill_outstanding", 32'(outstanding_o), 32'd4);
    step(4'h0, 1'b0, 1'b1, 32'h0000_00C2);
    check_eq("drain_rvalid_a", 32'(core_rvalid_o), 32'b0100);
    check_eq("drain_rdata_a",  core_rdata_o,       32'h0000_00C1);
    step(4'h0, 1'b0, 1'b1, 32'h0000_00C3);
    check_eq("drain_rvalid_b", 32'(core_rvalid_o), 32'b1000);
    step(4'h0, 1'b0, 1'b1, 32'h0000_00C4);
    check_eq("drain_rvalid_c", 32'(core_rvalid_o), 32'b0001);
    step(4'h0, 1'b0, 1'b0, 32'h0);
    check_eq("drain_rvalid_d", 32'(core_rvalid_o), 32'b0010);
    check_eq("drain_rdata_d",  core_rdata_o,       32'h0000_00C4);
    check_eq("drain_empty",    32'(outstanding_o), 32'd0);

    // Push and pop together at a fill level of 2.
    step(4'hF, 1'b1, 1'b0, 32'h0);
    check_eq("pp_gnt_a", 32'(core_gnt_o), 32'b0100);
    step(4'hF, 1'b1, 1'b0, 32'h0);
    check_eq("pp_gnt_b", 32'(core_gnt_o), 32'b1000);
    step(4'hF, 1'b1, 1'b1, 32'h0000_00D0);
    check_eq("pp_outstanding_before", 32'(outstanding_o), 32'd2);
    check_eq("pp_gnt_c",              32'(core_gnt_o),    32'b0001);
    step(4'hF, 1'b1, 1'b0, 32'h0);
    check_eq("pp_outstanding_after", 32'(outstanding_o), 32'd2);
    check_eq("pp_rvalid",            32'(core_rvalid_o), 32'b0100);
    check_eq("pp_rdata",             core_rdata_o,       32'h0000_00D0);
    check_eq("pp_gnt_d",             32'(core_gnt_o),    32'b0010);
    step(4'h0, 1'b0, 1'b0, 32'h0);
    check_eq("pre_rst_outstanding", 32'(outstanding_o), 32'd3);
    check_eq("pre_rst_spurious",    32'(spurious_o),    32'h0);

    // Reset with 3 outstanding, then a stale response arrives.
    apply_reset();
    step(4'h0, 1'b0, 1'b1, 32'h0000_00E0);
    check_eq("post_rst_outstanding", 32'(outstanding_o), 32'd0);
    step(4'hF, 1'b1, 1'b0, 32'h0);
    check_eq("spurious_set",     32'(spurious_o),    32'h1);
    check_eq("spurious_rvalid",  32'(core_rvalid_o), 32'h0);
    check_eq("post_rst_rr_gnt",  32'(core_gnt_o),    32'b0001);
    step(4'h0, 1'b0, 1'b0, 32'h0);
    check_eq("spurious_sticky",  32'(spurious_o),    32'h1);
    check_eq("post_rst_pushed",  32'(outstanding_o), 32'd1);
    apply_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
